mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The module SHALL have parameter LINE_ADDR_LEN, default 3, giving words per line as 2^LINE_ADDR_LEN.
REQ-002 The module SHALL have parameter ADDR_LEN, default 10, giving the line address width into main memory.
REQ-003 The module SHALL have one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 p0_rd_req, p0_wr_req  input  1 each  port 0 (instruction cache) read and write requests; held until p0_gnt.
REQ-007 p0_addr  input  ADDR_LEN  port 0 line address; p0_wr_line  input  32 x LINE_SIZE  port 0 write line.
REQ-008 p0_gnt  output  1  port 0 completion pulse; p0_rd_line  output  32 x LINE_SIZE  read data.
REQ-009 p1_rd_req, p1_wr_req, p1_addr, p1_wr_line, p1_gnt, p1_rd_line  SHALL mirror REQ-006 to REQ-008 for port 1 (data cache).
REQ-010 mem_rd_req, mem_wr_req  output  1 each  requests to main_mem.
REQ-011 mem_addr  output  ADDR_LEN  address to main_mem; mem_wr_line  output  32 x LINE_SIZE  write line to main_mem.
REQ-012 mem_gnt  input  1  main_mem completion pulse; mem_rd_line  input  32 x LINE_SIZE  read line from main_mem.
REQ-013 p0_cnt, p1_cnt  output  16 each  completed-transaction counters.
REQ-014 proto_err  output  1  sticky protocol-violation flag.

Function
REQ-015 The arbiter SHALL use the FSM states IDLE, BUSY0, BUSY1 and RELEASE.
REQ-016 A port SHALL be requesting when its rd_req or its wr_req is high.
REQ-017 In IDLE, if only one port is requesting, the FSM SHALL move to that port's BUSY state on the next edge.
REQ-018 In IDLE, if both ports are requesting, the FSM SHALL grant the port that is not last_owner (round-robin).
REQ-019 The 1-bit register last_owner SHALL be updated on entry to BUSY0 or BUSY1.
REQ-020 In BUSYn, mem_rd_req, mem_wr_req, mem_addr and mem_wr_line SHALL be driven combinationally from port n.
REQ-021 The non-owner port's requests SHALL be ignored and held pending while the other port owns the memory.
REQ-022 In IDLE and RELEASE, mem_rd_req and mem_wr_req SHALL be 0, and mem_addr and mem_wr_line SHALL be 0.
REQ-023 pn_gnt SHALL equal mem_gnt AND (state == BUSYn); it SHALL never be high for the non-owner.
REQ-024 On mem_gnt in BUSYn, the FSM SHALL go to RELEASE and pn_cnt SHALL increment, saturating at 16'hFFFF.
REQ-025 RELEASE SHALL last exactly one cycle, then return to IDLE, guaranteeing one dead cycle between memory transactions.
REQ-026 A write-then-read by the same port (dirty swap) SHALL be arbitrated as two independent transactions.
REQ-027 The other port may win between the two transactions of REQ-026 when it is pending.
REQ-028 Latency from a request in IDLE to the memory request SHALL be 1 cycle.
REQ-029 Latency from mem_gnt to the next transaction's memory request SHALL be 2 cycles (RELEASE, then IDLE).
REQ-030 p0_rd_line and p1_rd_line SHALL both be wired directly to mem_rd_line.
REQ-031 The owner SHALL consume rd_line only on the cycle its gnt is high.
REQ-032 If the owner drops its request in BUSYn before mem_gnt, the FSM SHALL return to IDLE and set proto_err.
REQ-033 proto_err SHALL also be set when any port asserts rd_req and wr_req together.
REQ-034 In the both-high case of REQ-033, the arbiter SHALL forward only the write.
REQ-035 A mem_gnt arriving in IDLE or RELEASE SHALL be ignored, and proto_err SHALL be set.

Reset
REQ-036 On rst, the FSM SHALL go to IDLE, last_owner SHALL be 1 (port 0 wins the first tie), the counters SHALL be 0 and proto_err SHALL be 0.
REQ-037 On rst, all mem_* outputs and both gnt outputs SHALL go to 0 immediately, including when reset asserts mid-transaction.
REQ-038 After reset, no in-flight transaction SHALL be resumed; requesters re-request.

Verification
REQ-039 Port 0 read, addr 10'h005: mem_rd_req=1 with mem_addr=10'h005 one cycle later; at mem_gnt, p0_gnt=1, p0_rd_line=mem_rd_line, p0_cnt=1, and memory requests are 0 for one cycle.
REQ-040 Both ports request at the first cycle after reset: port 0 is served first, then port 1 starts 2 cycles after port 0's gnt, with p1_cnt=1 and p0_cnt=1.
REQ-041 Port 1 dirty swap (write 10'h3A0 then read 10'h1A0) while port 0 is pending a read: the order is p1 write, p0 read, p1 read, and no gnt goes to a non-owner.
REQ-042 Assert rst while in BUSY1 with mem_wr_req=1: all outputs are 0 asynchronously, and on release the state is IDLE with counters 0.
REQ-043 Port 0 asserts rd_req and wr_req together: proto_err=1 and stays set until rst, and mem_wr_req=1 while mem_rd_req=0.
REQ-044 Force p0_cnt to 16'hFFFF and complete one more port 0 transaction: p0_cnt stays at 16'hFFFF.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported line memory.
// One dead RELEASE cycle separates consecutive memory transactions.
module mem_arbiter #(
  parameter int LINE_ADDR_LEN = 3,
  parameter int ADDR_LEN      = 10
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              p0_rd_req,
  input  logic                              p0_wr_req,
  input  logic [ADDR_LEN-1:0]               p0_addr,
  input  logic [32*(2**LINE_ADDR_LEN)-1:0]  p0_wr_line,
  output logic                              p0_gnt,
  output logic [32*(2**LINE_ADDR_LEN)-1:0]  p0_rd_line,
  input  logic                              p1_rd_req,
  input  logic                              p1_wr_req,
  input  logic [ADDR_LEN-1:0]               p1_addr,
  input  logic [32*(2**LINE_ADDR_LEN)-1:0]  p1_wr_line,
  output logic                              p1_gnt,
  output logic [32*(2**LINE_ADDR_LEN)-1:0]  p1_rd_line,
  output logic                              mem_rd_req,
  output logic                              mem_wr_req,
  output logic [ADDR_LEN-1:0]               mem_addr,
  output logic [32*(2**LINE_ADDR_LEN)-1:0]  mem_wr_line,
  input  logic                              mem_gnt,
  input  logic [32*(2**LINE_ADDR_LEN)-1:0]  mem_rd_line,
  output logic [15:0]                       p0_cnt,
  output logic [15:0]                       p1_cnt,
  output logic                              proto_err
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] BUSY0   = 2'd1;
  localparam logic [1:0] BUSY1   = 2'd2;
  localparam logic [1:0] RELEASE = 2'd3;

  logic [1:0]  r_state;
  logic [1:0]  w_next;
  logic        r_last_owner;
  logic [15:0] r_p0_cnt;
  logic [15:0] r_p1_cnt;
  logic        r_proto_err;
  logic        w_req0;
  logic        w_req1;
  logic        w_err;

  assign w_req0 = p0_rd_req | p0_wr_req;
  assign w_req1 = p1_rd_req | p1_wr_req;

  assign p0_gnt     = mem_gnt & (r_state == BUSY0);
  assign p1_gnt     = mem_gnt & (r_state == BUSY1);
  assign p0_rd_line = mem_rd_line;
  assign p1_rd_line = mem_rd_line;
  assign p0_cnt     = r_p0_cnt;
  assign p1_cnt     = r_p1_cnt;
  assign proto_err  = r_proto_err;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_req0 && w_req1) w_next = r_last_owner ? BUSY0 : BUSY1;
        else if (w_req0)      w_next = BUSY0;
        else if (w_req1)      w_next = BUSY1;
      end
      BUSY0: begin
        if (mem_gnt)      w_next = RELEASE;
        else if (!w_req0) w_next = IDLE;
      end
      BUSY1: begin
        if (mem_gnt)      w_next = RELEASE;
        else if (!w_req1) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Simultaneous rd+wr forwards only the write; outside BUSYn everything is zero.
  always_comb begin
    mem_rd_req  = 1'b0;
    mem_wr_req  = 1'b0;
    mem_addr    = '0;
    mem_wr_line = '0;
    if (r_state == BUSY0) begin
      mem_rd_req  = p0_rd_req & ~p0_wr_req;
      mem_wr_req  = p0_wr_req;
      mem_addr    = p0_addr;
      mem_wr_line = p0_wr_line;
    end else if (r_state == BUSY1) begin
      mem_rd_req  = p1_rd_req & ~p1_wr_req;
      mem_wr_req  = p1_wr_req;
      mem_addr    = p1_addr;
      mem_wr_line = p1_wr_line;
    end
  end

  assign w_err = (p0_rd_req & p0_wr_req) | (p1_rd_req & p1_wr_req)
               | (mem_gnt & ((r_state == IDLE) | (r_state == RELEASE)))
               | ((r_state == BUSY0) & ~mem_gnt & ~w_req0)
               | ((r_state == BUSY1) & ~mem_gnt & ~w_req1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last_owner <= 1'b1;
      r_p0_cnt     <= '0;
      r_p1_cnt     <= '0;
      r_proto_err  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_next == BUSY0) r_last_owner <= 1'b0;
      if (r_state == IDLE && w_next == BUSY1) r_last_owner <= 1'b1;
      if (p0_gnt && r_p0_cnt != '1) r_p0_cnt <= r_p0_cnt + 16'd1;
      if (p1_gnt && r_p1_cnt != '1) r_p1_cnt <= r_p1_cnt + 16'd1;
      if (w_err) r_proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single, tie, dirty swap, reset, protocol errors, saturation.
module tb_mem_arbiter;

  localparam int LW = 256;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          p0_rd_req, p0_wr_req, p1_rd_req, p1_wr_req;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [LW-1:0] p0_wr_line, p1_wr_line, p0_rd_line, p1_rd_line;
  logic          p0_gnt, p1_gnt;
  logic          mem_rd_req, mem_wr_req, mem_gnt;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wr_line, mem_rd_line;
  logic [15:0]   p0_cnt, p1_cnt;
  logic          proto_err;

  int unsigned tests = 0;
  int unsigned fails = 0;

  logic [LW-1:0] pat_a, pat_b, pat_c, pat_d;

  mem_arbiter #(.LINE_ADDR_LEN(3), .ADDR_LEN(AW)) dut (
    .clk(clk), .rst(rst),
    .p0_rd_req(p0_rd_req), .p0_wr_req(p0_wr_req), .p0_addr(p0_addr),
    .p0_wr_line(p0_wr_line), .p0_gnt(p0_gnt), .p0_rd_line(p0_rd_line),
    .p1_rd_req(p1_rd_req), .p1_wr_req(p1_wr_req), .p1_addr(p1_addr),
    .p1_wr_line(p1_wr_line), .p1_gnt(p1_gnt), .p1_rd_line(p1_rd_line),
    .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
    .mem_wr_line(mem_wr_line), .mem_gnt(mem_gnt), .mem_rd_line(mem_rd_line),
    .p0_cnt(p0_cnt), .p1_cnt(p1_cnt), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    pat_a = {8{32'hA5A5_0001}};
    pat_b = {8{32'hB0B0_1234}};
    pat_c = {8{32'hC3C3_5678}};
    pat_d = {8{32'hD00D_9ABC}};
    rst = 1'b1;
    p0_rd_req = 0; p0_wr_req = 0; p0_addr = '0; p0_wr_line = '0;
    p1_rd_req = 0; p1_wr_req = 0; p1_addr = '0; p1_wr_line = '0;
    mem_gnt = 0; mem_rd_line = '0;
    step(); step();
    rst = 1'b0;
    step();
    chk("rst_p0_cnt", p0_cnt, 0);
    chk("rst_p1_cnt", p1_cnt, 0);
    chk("rst_proto_err", proto_err, 0);
    chk("rst_mem_rd", mem_rd_req, 0);
    chk("rst_mem_addr", mem_addr, 0);

    // Single port 0 read
    p0_rd_req = 1; p0_addr = 10'h005; #1;
    chk("t1_idle_rd", mem_rd_req, 0);
    step();
    chk("t1_mem_rd", mem_rd_req, 1);
    chk("t1_mem_addr", mem_addr, 10'h005);
    chk("t1_p0_gnt_early", p0_gnt, 0);
    mem_gnt = 1; mem_rd_line = pat_a; #1;
    chk("t1_p0_gnt", p0_gnt, 1);
    chk("t1_p0_line", p0_rd_line, pat_a);
    chk("t1_p1_gnt", p1_gnt, 0);
    step();
    mem_gnt = 0; p0_rd_req = 0; #1;
    chk("t1_p0_cnt", p0_cnt, 1);
    chk("t1_release_rd", mem_rd_req, 0);
    chk("t1_release_addr", mem_addr, 0);
    step();
    chk("t1_idle_after", mem_rd_req, 0);

    // Tie right after reset: port 0 first
    rst = 1; step();
    rst = 0;
    p0_rd_req = 1; p0_addr = 10'h011; p1_rd_req = 1; p1_addr = 10'h022;
    chk("t2_p0_cnt_rst", p0_cnt, 0);
    step();
    chk("t2_first_addr", mem_addr, 10'h011);
    chk("t2_first_rd", mem_rd_req, 1);
    mem_gnt = 1; #1;
    chk("t2_p0_gnt", p0_gnt, 1);
    chk("t2_p1_gnt_no", p1_gnt, 0);
    step();
    mem_gnt = 0; p0_rd_req = 0; #1;
    chk("t2_release_rd", mem_rd_req, 0);
    step();
    chk("t2_idle_rd", mem_rd_req, 0);
    step();
    chk("t2_second_rd", mem_rd_req, 1);
    chk("t2_second_addr", mem_addr, 10'h022);
    mem_gnt = 1; #1;
    chk("t2_p1_gnt", p1_gnt, 1);
    chk("t2_p0_gnt_no", p0_gnt, 0);
    step();
    mem_gnt = 0; p1_rd_req = 0;
    chk("t2_p1_cnt", p1_cnt, 1);
    chk("t2_p0_cnt", p0_cnt, 1);

    // Port 1 dirty swap with port 0 pending
    step();
    p1_wr_req = 1; p1_addr = 10'h3A0; p1_wr_line = pat_b;
    step();
    chk("t3_wr_req", mem_wr_req, 1);
    chk("t3_wr_rd", mem_rd_req, 0);
    chk("t3_wr_addr", mem_addr, 10'h3A0);
    chk("t3_wr_line", mem_wr_line, pat_b);
    p0_rd_req = 1; p0_addr = 10'h044; #1;
    chk("t3_nonowner_ignored", mem_addr, 10'h3A0);
    mem_gnt = 1; #1;
    chk("t3_wr_p1_gnt", p1_gnt, 1);
    chk("t3_wr_p0_gnt", p0_gnt, 0);
    step();
    mem_gnt = 0; p1_wr_req = 0; p1_rd_req = 1; p1_addr = 10'h1A0; #1;
    chk("t3_release_wr", mem_wr_req, 0);
    chk("t3_release_rd", mem_rd_req, 0);
    step();
    step();
    chk("t3_p0_addr", mem_addr, 10'h044);
    chk("t3_p0_rd", mem_rd_req, 1);
    mem_gnt = 1; #1;
    chk("t3_p0_gnt", p0_gnt, 1);
    chk("t3_p1_gnt_no", p1_gnt, 0);
    step();
    mem_gnt = 0; p0_rd_req = 0;
    step();
    step();
    chk("t3_p1_rd_addr", mem_addr, 10'h1A0);
    chk("t3_p1_rd", mem_rd_req, 1);
    mem_gnt = 1; #1;
    chk("t3_p1_gnt", p1_gnt, 1);
    step();
    mem_gnt = 0; p1_rd_req = 0;
    chk("t3_p1_cnt", p1_cnt, 3);
    chk("t3_p0_cnt", p0_cnt, 2);
    chk("t3_no_err", proto_err, 0);

    // Asynchronous reset mid-write in BUSY1
    step();
    p1_wr_req = 1; p1_addr = 10'h0F0; p1_wr_line = pat_c;
    step();
    chk("t4_busy_wr", mem_wr_req, 1);
    mem_gnt = 1; rst = 1; #1;
    chk("t4_async_wr", mem_wr_req, 0);
    chk("t4_async_addr", mem_addr, 0);
    chk("t4_async_line", mem_wr_line, 0);
    chk("t4_async_gnt", p1_gnt, 0);
    chk("t4_async_cnt", p1_cnt, 0);
    p1_wr_req = 0; mem_gnt = 0;
    step();
    rst = 0;
    step();
    chk("t4_idle_wr", mem_wr_req, 0);
    chk("t4_p0_cnt", p0_cnt, 0);
    chk("t4_p1_cnt", p1_cnt, 0);
    chk("t4_err", proto_err, 0);

    // Stray mem_gnt in IDLE
    mem_gnt = 1;
    step();
    mem_gnt = 0;
    chk("t5_stray_err", proto_err, 1);
    chk("t5_stray_cnt0", p0_cnt, 0);
    chk("t5_stray_cnt1", p1_cnt, 0);

    // Owner drops request before mem_gnt
    rst = 1; step();
    rst = 0;
    chk("t6_err_cleared", proto_err, 0);
    p0_rd_req = 1; p0_addr = 10'h009;
    step();
    chk("t6_busy_rd", mem_rd_req, 1);
    p0_rd_req = 0;
    step();
    chk("t6_drop_err", proto_err, 1);
    chk("t6_drop_cnt", p0_cnt, 0);
    p1_rd_req = 1; p1_addr = 10'h055;
    step();
    chk("t6_back_idle", mem_addr, 10'h055);
    mem_gnt = 1;
    step();
    mem_gnt = 0; p1_rd_req = 0;
    chk("t6_p1_cnt", p1_cnt, 1);

    // Read and write together: only the write is forwarded
    rst = 1; step();
    rst = 0;
    p0_rd_req = 1; p0_wr_req = 1; p0_addr = 10'h077; p0_wr_line = pat_d;
    step();
    chk("t7_wr", mem_wr_req, 1);
    chk("t7_rd", mem_rd_req, 0);
    chk("t7_line", mem_wr_line, pat_d);
    chk("t7_err", proto_err, 1);
    mem_gnt = 1;
    step();
    mem_gnt = 0; p0_rd_req = 0; p0_wr_req = 0;
    step();
    step();
    chk("t7_err_sticky", proto_err, 1);
    chk("t7_p0_cnt", p0_cnt, 1);

    // Counter saturation
    rst = 1; step();
    rst = 0;
    force dut.r_p0_cnt = 16'hFFFF;
    #1;
    release dut.r_p0_cnt;
    p0_rd_req = 1; p0_addr = 10'h100;
    step();
    mem_gnt = 1; #1;
    chk("t8_p0_gnt", p0_gnt, 1);
    step();
    mem_gnt = 0; p0_rd_req = 0;
    chk("t8_sat", p0_cnt, 16'hFFFF);
    chk("t8_p1_cnt", p1_cnt, 0);

    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
